// File: rtl/writeback_stage_multi_if.sv
// Memory-to-writeback bundle: M-side instruction fields and stall/flush in, W-side
// register-file write port, forwarding data and retire count out.
interface writeback_stage_multi_if #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int CNTW  = 32
);
  logic                    StallW;
  logic                    FlushW;
  logic [LANES-1:0]        ValidM;
  logic [LANES-1:0]        RegWriteM;
  logic [LANES*REGW-1:0]   RdM;
  logic [LANES*2-1:0]      ResultSrcM;
  logic [LANES*3-1:0]      LoadTypeM;
  logic [LANES*XLEN-1:0]   ALUResultM;
  logic [LANES*XLEN-1:0]   ReadDataM;
  logic [LANES*XLEN-1:0]   PCPlus4M;

  logic [LANES-1:0]        ValidW;
  logic [LANES-1:0]        RegWriteW;
  logic [LANES*REGW-1:0]   RdW;
  logic [LANES*XLEN-1:0]   ResultW;
  logic [CNTW-1:0]         RetireCount;

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, LoadTypeM,
           ALUResultM, ReadDataM, PCPlus4M,
    input  ValidW, RegWriteW, RdW, ResultW, RetireCount
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, LoadTypeM,
           ALUResultM, ReadDataM, PCPlus4M,
    output ValidW, RegWriteW, RdW, ResultW, RetireCount
  );
endinterface

// File: rtl/writeback_stage_multi.sv
// N-lane MEM/WB register with load extension, result select, x0 / same-rd write
// suppression (youngest lane wins) and a retired-instruction counter. One cycle M->W.
module writeback_stage_multi #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int CNTW  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  writeback_stage_multi_if.slave wb
);

  logic [LANES-1:0]      valid_q,    valid_d;
  logic [LANES-1:0]      regwrite_q, regwrite_d;
  logic [LANES*REGW-1:0] rd_q,       rd_d;
  logic [LANES*2-1:0]    src_q,      src_d;
  logic [LANES*3-1:0]    ltype_q,    ltype_d;
  logic [LANES*XLEN-1:0] alu_q,      alu_d;
  logic [LANES*XLEN-1:0] rdata_q,    rdata_d;
  logic [LANES*XLEN-1:0] pc4_q,      pc4_d;
  logic [CNTW-1:0]       count_q,    count_d;

  logic [LANES-1:0]      killed;
  logic [LANES-1:0]      regwrite_w;
  logic [LANES*XLEN-1:0] result_w;

  function automatic logic [CNTW-1:0] popcount(input logic [LANES-1:0] v);
    logic [CNTW-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + CNTW'(v[i]);
    return n;
  endfunction

  // Offset comes from the low address bits; halfwords ignore off[0].
  function automatic logic [XLEN-1:0] extend_load(input logic [2:0]      lt,
                                                  input logic [1:0]      off,
                                                  input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (lt)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    src_d      = src_q;
    ltype_d    = ltype_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    pc4_d      = pc4_q;
    count_d    = count_q;
    if (wb.FlushW) begin
      valid_d    = '0;
      regwrite_d = '0;
    end else if (!wb.StallW) begin
      valid_d    = wb.ValidM;
      regwrite_d = wb.RegWriteM;
      rd_d       = wb.RdM;
      src_d      = wb.ResultSrcM;
      ltype_d    = wb.LoadTypeM;
      alu_d      = wb.ALUResultM;
      rdata_d    = wb.ReadDataM;
      pc4_d      = wb.PCPlus4M;
      count_d    = count_q + popcount(wb.ValidM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      rd_q       <= '0;
      src_q      <= '0;
      ltype_q    <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      src_q      <= src_d;
      ltype_q    <= ltype_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      pc4_q      <= pc4_d;
      count_q    <= count_d;
    end
  end

  // A lane loses its write when any younger lane writes the same nonzero rd.
  always_comb begin
    killed = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (valid_q[j] && regwrite_q[j] &&
            (rd_q[j*REGW +: REGW] == rd_q[i*REGW +: REGW]) &&
            (rd_q[j*REGW +: REGW] != '0))
          killed[i] = 1'b1;
      end
    end
  end

  always_comb begin
    result_w   = '0;
    regwrite_w = '0;
    for (int i = 0; i < LANES; i++) begin
      case (src_q[i*2 +: 2])
        2'b01:   result_w[i*XLEN +: XLEN] = extend_load(ltype_q[i*3 +: 3],
                                                        alu_q[i*XLEN +: 2],
                                                        rdata_q[i*XLEN +: XLEN]);
        2'b10:   result_w[i*XLEN +: XLEN] = pc4_q[i*XLEN +: XLEN];
        default: result_w[i*XLEN +: XLEN] = alu_q[i*XLEN +: XLEN];
      endcase
      regwrite_w[i] = valid_q[i] & regwrite_q[i] &
                      (rd_q[i*REGW +: REGW] != '0) & ~killed[i];
    end
  end

  assign wb.ValidW      = valid_q;
  assign wb.RegWriteW   = regwrite_w;
  assign wb.RdW         = rd_q;
  assign wb.ResultW     = result_w;
  assign wb.RetireCount = count_q;

endmodule

// File: tb/tb_writeback_stage_multi.sv
// Directed and randomized bench for the two-lane writeback stage; a second instance
// with a 4-bit counter shares the same inputs to exercise counter wrap.
module tb_writeback_stage_multi;

  typedef struct {
    bit        v;
    bit        rw;
    bit [4:0]  rd;
    bit [1:0]  src;
    bit [2:0]  lt;
    bit [31:0] alu;
    bit [31:0] rdata;
    bit [31:0] pc4;
  } lane_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_stage_multi_if #(.LANES(2), .XLEN(32), .REGW(5), .CNTW(32)) ifc ();
  writeback_stage_multi_if #(.LANES(2), .XLEN(32), .REGW(5), .CNTW(4))  ifc4 ();

  assign ifc4.StallW     = ifc.StallW;
  assign ifc4.FlushW     = ifc.FlushW;
  assign ifc4.ValidM     = ifc.ValidM;
  assign ifc4.RegWriteM  = ifc.RegWriteM;
  assign ifc4.RdM        = ifc.RdM;
  assign ifc4.ResultSrcM = ifc.ResultSrcM;
  assign ifc4.LoadTypeM  = ifc.LoadTypeM;
  assign ifc4.ALUResultM = ifc.ALUResultM;
  assign ifc4.ReadDataM  = ifc.ReadDataM;
  assign ifc4.PCPlus4M   = ifc.PCPlus4M;

  writeback_stage_multi #(.LANES(2), .XLEN(32), .REGW(5), .CNTW(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb(ifc.slave));
  writeback_stage_multi #(.LANES(2), .XLEN(32), .REGW(5), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .wb(ifc4.slave));

  int checks = 0;
  int errors = 0;

  lane_t in_l[2];
  bit    stall, flush;
  lane_t m[2];
  bit [31:0] cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference load/result semantics expressed as shifts and masks.
  function automatic bit [31:0] exp_result(input lane_t l);
    int unsigned off;
    bit [31:0] byt, half;
    off  = l.alu & 32'd3;
    byt  = (l.rdata >> (8 * off)) & 32'hFF;
    half = (l.rdata >> (16 * (off / 2))) & 32'hFFFF;
    if (l.src == 2'd2) return l.pc4;
    if (l.src != 2'd1) return l.alu;
    case (l.lt)
      3'd0:    return (byt >= 128) ? (byt | 32'hFFFFFF00) : byt;
      3'd4:    return byt;
      3'd1:    return (half >= 32768) ? (half | 32'hFFFF0000) : half;
      3'd5:    return half;
      default: return l.rdata;
    endcase
  endfunction

  function automatic bit [1:0] exp_we();
    int owner[32];
    bit [1:0] we;
    for (int r = 0; r < 32; r++) owner[r] = -1;
    for (int j = 0; j < 2; j++)
      if (m[j].v && m[j].rw && m[j].rd != 0) owner[m[j].rd] = j;
    we = '0;
    for (int i = 0; i < 2; i++)
      we[i] = m[i].v && m[i].rw && m[i].rd != 0 && owner[m[i].rd] == i;
    return we;
  endfunction

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      ifc.ValidM[i]                = in_l[i].v;
      ifc.RegWriteM[i]             = in_l[i].rw;
      ifc.RdM[i*5 +: 5]            = in_l[i].rd;
      ifc.ResultSrcM[i*2 +: 2]     = in_l[i].src;
      ifc.LoadTypeM[i*3 +: 3]      = in_l[i].lt;
      ifc.ALUResultM[i*32 +: 32]   = in_l[i].alu;
      ifc.ReadDataM[i*32 +: 32]    = in_l[i].rdata;
      ifc.PCPlus4M[i*32 +: 32]     = in_l[i].pc4;
    end
    ifc.StallW = stall;
    ifc.FlushW = flush;
  endtask

  task automatic model_edge();
    if (flush) begin
      for (int i = 0; i < 2; i++) begin m[i].v = 0; m[i].rw = 0; end
    end else if (!stall) begin
      for (int i = 0; i < 2; i++) begin
        m[i] = in_l[i];
        if (in_l[i].v) cnt = cnt + 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m[i] = '{default: 0};
    cnt = 0;
  endtask

  task automatic check_all(input string ph);
    check({ph, " ValidW"}, 64'(ifc.ValidW), 64'({m[1].v, m[0].v}));
    check({ph, " RegWriteW"}, 64'(ifc.RegWriteW), 64'(exp_we()));
    for (int i = 0; i < 2; i++) begin
      if (m[i].v) begin
        check($sformatf("%s RdW[%0d]", ph, i), 64'(ifc.RdW[i*5 +: 5]), 64'(m[i].rd));
        check($sformatf("%s ResultW[%0d]", ph, i), 64'(ifc.ResultW[i*32 +: 32]),
              64'(exp_result(m[i])));
      end
    end
    check({ph, " RetireCount"}, 64'(ifc.RetireCount), 64'(cnt));
    check({ph, " RetireCount4"}, 64'(ifc4.RetireCount), 64'(cnt & 32'hF));
  endtask

  task automatic step(input string ph);
    drive();
    @(posedge clk);
    model_edge();
    #2;
    check_all(ph);
  endtask

  // Assert reset mid-cycle and confirm outputs clear before any clock edge.
  task automatic pulse_reset(input string ph);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({ph, " rst ValidW"}, 64'(ifc.ValidW), 64'd0);
    check({ph, " rst RegWriteW"}, 64'(ifc.RegWriteW), 64'd0);
    check({ph, " rst RdW"}, 64'(ifc.RdW), 64'd0);
    check({ph, " rst ResultW"}, 64'(ifc.ResultW), 64'd0);
    check({ph, " rst RetireCount"}, 64'(ifc.RetireCount), 64'd0);
    check({ph, " rst RetireCount4"}, 64'(ifc4.RetireCount), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_lane(input int i, input bit v, input bit rw, input bit [4:0] rd,
                          input bit [1:0] src, input bit [2:0] lt, input bit [31:0] alu,
                          input bit [31:0] rdata, input bit [31:0] pc4);
    in_l[i] = '{v: v, rw: rw, rd: rd, src: src, lt: lt, alu: alu, rdata: rdata, pc4: pc4};
  endtask

  initial begin
    bit [31:0] cnt_before;
    model_reset();
    stall = 0;
    flush = 0;
    for (int i = 0; i < 2; i++) set_lane(i, 0, 0, 0, 0, 0, 0, 0, 0);
    drive();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Load nonzero state, then reset asynchronously with all inputs nonzero
    set_lane(0, 1, 1, 5'd3, 2'd3, 3'd7, 32'hDEAD0001, 32'h11111111, 32'h22222222);
    set_lane(1, 1, 1, 5'd4, 2'd2, 3'd6, 32'hBEEF0002, 32'h33333333, 32'h44444444);
    stall = 0; flush = 0;
    step("pre-reset 1");
    step("pre-reset 2");
    stall = 1; flush = 1;
    drive();
    pulse_reset("reset");
    stall = 0; flush = 0;

    // Basic capture
    set_lane(0, 1, 1, 5'd5, 2'd0, 3'd2, 32'h1234, 32'h0, 32'h0);
    set_lane(1, 1, 1, 5'd6, 2'd2, 3'd2, 32'h9999, 32'h0, 32'h104);
    step("basic");
    check("basic ResultW", 64'(ifc.ResultW), 64'h00000104_00001234);
    check("basic RegWriteW", 64'(ifc.RegWriteW), 64'd3);
    check("basic RetireCount", 64'(ifc.RetireCount), 64'd2);

    // Load extension, offset 3 bytes then offset 2 halves
    set_lane(0, 1, 1, 5'd8, 2'd1, 3'd0, 32'h1003, 32'h80FF7F01, 32'h0);
    set_lane(1, 1, 1, 5'd9, 2'd1, 3'd4, 32'h2003, 32'h80FF7F01, 32'h0);
    step("byte");
    check("LB", 64'(ifc.ResultW[31:0]), 64'hFFFFFF80);
    check("LBU", 64'(ifc.ResultW[63:32]), 64'h00000080);
    set_lane(0, 1, 1, 5'd8, 2'd1, 3'd1, 32'h1002, 32'h80FF7F01, 32'h0);
    set_lane(1, 1, 1, 5'd9, 2'd1, 3'd5, 32'h2002, 32'h80FF7F01, 32'h0);
    step("half");
    check("LH", 64'(ifc.ResultW[31:0]), 64'hFFFF80FF);
    check("LHU", 64'(ifc.ResultW[63:32]), 64'h000080FF);

    // Same-rd conflict, then rd=0 on the younger lane
    set_lane(0, 1, 1, 5'd7, 2'd0, 3'd2, 32'hAAAA0000, 32'h0, 32'h0);
    set_lane(1, 1, 1, 5'd7, 2'd0, 3'd2, 32'hBBBB0000, 32'h0, 32'h0);
    step("same-rd");
    check("same-rd RegWriteW", 64'(ifc.RegWriteW), 64'b10);
    check("same-rd lane1 data", 64'(ifc.ResultW[63:32]), 64'hBBBB0000);
    set_lane(1, 1, 1, 5'd0, 2'd0, 3'd2, 32'hCCCC0000, 32'h0, 32'h0);
    step("x0");
    check("x0 RegWriteW", 64'(ifc.RegWriteW), 64'b01);

    // Stall three cycles while M changes
    set_lane(0, 1, 1, 5'd10, 2'd0, 3'd2, 32'h0A0A0A0A, 32'h0, 32'h0);
    set_lane(1, 1, 0, 5'd11, 2'd2, 3'd2, 32'h0, 32'h0, 32'h0B0B0B0B);
    step("pre-stall");
    cnt_before = cnt;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 1, 1, 5'(k + 20), 2'd0, 3'd2, $urandom, $urandom, $urandom);
      set_lane(1, 1, 1, 5'(k + 25), 2'd0, 3'd2, $urandom, $urandom, $urandom);
      step("stall");
      check("stall ResultW0", 64'(ifc.ResultW[31:0]), 64'h0A0A0A0A);
      check("stall RegWriteW", 64'(ifc.RegWriteW), 64'b01);
      check("stall count", 64'(ifc.RetireCount), 64'(cnt_before));
    end

    // Flush together with stall
    flush = 1;
    step("flush+stall");
    check("flush ValidW", 64'(ifc.ValidW), 64'd0);
    check("flush RegWriteW", 64'(ifc.RegWriteW), 64'd0);
    check("flush count", 64'(ifc.RetireCount), 64'(cnt_before));
    stall = 0; flush = 0;

    // Counter wrap on the 4-bit instance
    pulse_reset("wrap");
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 1, 1, 5'd1, 2'd0, 3'd2, $urandom, 32'h0, 32'h0);
      set_lane(1, 1, 1, 5'd2, 2'd0, 3'd2, $urandom, 32'h0, 32'h0);
      step("wrap");
    end
    check("wrap RetireCount4", 64'(ifc4.RetireCount), 64'd0);
    check("wrap RetireCount", 64'(ifc.RetireCount), 64'd16);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 2; i++)
        set_lane(i, 1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 3)),
                 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
